// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared state/packet types and default timing for the tx scheduler
// Contents:
//   sched_state_t : scheduler FSM states
//   pkt_kind_t    : packet kind chosen by arbitration
//   DEF_*         : default parameter values used by tx_scheduler and tx_sched_arb
package tx_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      WAIT_DONE  = 2'd2,
      GAP        = 2'd3
   } sched_state_t;

   typedef enum logic [1:0] {
      PK_DATA = 2'd0,
      PK_ACK  = 2'd1,
      PK_NAK  = 2'd2
   } pkt_kind_t;

   localparam int DEF_CNT_W         = 7;
   localparam int DEF_DATA_THRESH   = 8;
   localparam int DEF_GAP_CYCLES    = 16;
   localparam int DEF_START_TIMEOUT = 8;
   localparam int DEF_DONE_TIMEOUT  = 4096;
   localparam int DEF_STARVE_LIMIT  = 4;

endpackage

// File: rtl/tx_sched_arb.sv
// rtl/tx_sched_arb.sv - combinational packet priority select and starve counter next-state
// Ports:
//   arb_en      in   arbitration allowed this cycle (scheduler is IDLE)
//   ack_p       in   ACK pending (including a request arriving this cycle)
//   nak_p       in   NAK pending (including a request arriving this cycle)
//   data_p      in   data pending (including a request arriving this cycle)
//   data_elig   in   data pending and FIFO threshold met or flush requested
//   starve_cnt  in   current count of handshake wins over pending data
//   grant       out  selected packet kind
//   grant_valid out  a packet is selected this cycle
//   conflict    out  NAK selected while an ACK was also pending
//   starve_nxt  out  next value of the starve counter
module tx_sched_arb
   import tx_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
   input  logic          arb_en,
   input  logic          ack_p,
   input  logic          nak_p,
   input  logic          data_p,
   input  logic          data_elig,
   input  logic [SW-1:0] starve_cnt,
   output pkt_kind_t     grant,
   output logic          grant_valid,
   output logic          conflict,
   output logic [SW-1:0] starve_nxt
);

   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic hs_p;
   logic starved;

   assign hs_p    = ack_p | nak_p;
   assign starved = (starve_cnt == LIMIT);

   always_comb begin
      grant       = PK_ACK;
      grant_valid = 1'b0;
      conflict    = 1'b0;
      starve_nxt  = starve_cnt;

      if (arb_en) begin
         // Data only wins over a pending handshake once it has been starved.
         if (data_elig && (starved || !hs_p)) begin
            grant       = PK_DATA;
            grant_valid = 1'b1;
         end else if (nak_p) begin
            grant       = PK_NAK;
            grant_valid = 1'b1;
            conflict    = ack_p;
         end else if (ack_p) begin
            grant       = PK_ACK;
            grant_valid = 1'b1;
         end
      end

      if (!data_p) begin
         starve_nxt = '0;
      end else if (grant_valid) begin
         if (grant == PK_DATA) begin
            starve_nxt = '0;
         end else if (!starved) begin
            starve_nxt = starve_cnt + SW'(1);
         end
      end
   end

endmodule

// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - arbitrates ACK/NAK/data transmit requests and tracks each packet to completion
// Ports:
//   clk          in   system clock
//   n_rst        in   asynchronous active-low reset
//   ack_req      in   pulse: receiver wants ACK sent
//   nak_req      in   pulse: receiver wants NAK sent
//   data_req     in   pulse: host token requests a data packet
//   data_flush   in   level: launch data regardless of FIFO threshold
//   fifo_count   in   bytes currently in TX FIFO
//   tx_busy      in   sending flag from transmit control unit
//   clear_err    in   pulse: clears timeout_err
//   tx_transmit  out  one-cycle start of data packet
//   tx_send_good out  one-cycle start of ACK
//   tx_send_bad  out  one-cycle start of NAK
//   busy         out  scheduler not IDLE
//   pkt_done     out  one-cycle pulse at packet completion
//   hs_conflict  out  one-cycle pulse when ACK and NAK collide at arbitration
//   timeout_err  out  sticky watchdog error flag
module tx_scheduler
   import tx_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int DATA_THRESH   = DEF_DATA_THRESH,
   parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT,
   parameter int DONE_TIMEOUT  = DEF_DONE_TIMEOUT,
   parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             ack_req,
   input  logic             nak_req,
   input  logic             data_req,
   input  logic             data_flush,
   input  logic [CNT_W-1:0] fifo_count,
   input  logic             tx_busy,
   input  logic             clear_err,
   output logic             tx_transmit,
   output logic             tx_send_good,
   output logic             tx_send_bad,
   output logic             busy,
   output logic             pkt_done,
   output logic             hs_conflict,
   output logic             timeout_err
);

   localparam int TMR_W = $clog2(DONE_TIMEOUT) + 1;
   localparam int SW    = $clog2(STARVE_LIMIT + 1);

   localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] DONE_LAST  = TMR_W'(DONE_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] THRESH     = CNT_W'(DATA_THRESH);

   sched_state_t     state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             ack_p_q, ack_p_d;
   logic             nak_p_q, nak_p_d;
   logic             data_p_q, data_p_d;
   logic             tx_transmit_q, tx_transmit_d;
   logic             tx_send_good_q, tx_send_good_d;
   logic             tx_send_bad_q, tx_send_bad_d;
   logic             busy_q, busy_d;
   logic             pkt_done_q, pkt_done_d;
   logic             hs_conflict_q, hs_conflict_d;
   logic             timeout_err_q, timeout_err_d;

   // Requests arriving this cycle take part in arbitration immediately so the
   // registered start pulse follows the request by exactly one cycle.
   logic ack_eff, nak_eff, data_eff, data_elig;
   logic arb_en, grant_valid, conflict, err_set;
   pkt_kind_t grant;

   assign ack_eff   = ack_p_q | ack_req;
   assign nak_eff   = nak_p_q | nak_req;
   assign data_eff  = data_p_q | data_req;
   assign data_elig = data_eff && ((fifo_count >= THRESH) || data_flush);
   assign arb_en    = (state_q == IDLE);

   tx_sched_arb #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .arb_en      (arb_en),
      .ack_p       (ack_eff),
      .nak_p       (nak_eff),
      .data_p      (data_eff),
      .data_elig   (data_elig),
      .starve_cnt  (starve_q),
      .grant       (grant),
      .grant_valid (grant_valid),
      .conflict    (conflict),
      .starve_nxt  (starve_d)
   );

   always_comb begin
      state_d        = state_q;
      tmr_d          = tmr_q;
      ack_p_d        = ack_eff;
      nak_p_d        = nak_eff;
      data_p_d       = data_eff;
      tx_transmit_d  = 1'b0;
      tx_send_good_d = 1'b0;
      tx_send_bad_d  = 1'b0;
      pkt_done_d     = 1'b0;
      hs_conflict_d  = 1'b0;
      err_set        = 1'b0;

      case (state_q)
         IDLE: begin
            tmr_d = '0;
            if (grant_valid) begin
               state_d = WAIT_START;
               case (grant)
                  PK_DATA: begin
                     tx_transmit_d = 1'b1;
                     data_p_d      = 1'b0;
                  end
                  PK_NAK: begin
                     // A NAK supersedes any ACK pending alongside it.
                     tx_send_bad_d = 1'b1;
                     nak_p_d       = 1'b0;
                     ack_p_d       = 1'b0;
                     hs_conflict_d = conflict;
                  end
                  default: begin
                     tx_send_good_d = 1'b1;
                     ack_p_d        = 1'b0;
                  end
               endcase
            end
         end
         WAIT_START: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
               tmr_d   = '0;
            end else if (tmr_q == START_LAST) begin
               err_set = 1'b1;
               state_d = GAP;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               pkt_done_d = 1'b1;
               state_d    = GAP;
               tmr_d      = '0;
            end else if (tmr_q == DONE_LAST) begin
               err_set = 1'b1;
               state_d = GAP;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         GAP: begin
            if (tmr_q == GAP_LAST) begin
               state_d = IDLE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
      endcase

      // A new timeout wins over a simultaneous clear.
      timeout_err_d = err_set | (timeout_err_q & ~clear_err);
      busy_d        = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         tmr_q          <= '0;
         starve_q       <= '0;
         ack_p_q        <= 1'b0;
         nak_p_q        <= 1'b0;
         data_p_q       <= 1'b0;
         tx_transmit_q  <= 1'b0;
         tx_send_good_q <= 1'b0;
         tx_send_bad_q  <= 1'b0;
         busy_q         <= 1'b0;
         pkt_done_q     <= 1'b0;
         hs_conflict_q  <= 1'b0;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         tmr_q          <= tmr_d;
         starve_q       <= starve_d;
         ack_p_q        <= ack_p_d;
         nak_p_q        <= nak_p_d;
         data_p_q       <= data_p_d;
         tx_transmit_q  <= tx_transmit_d;
         tx_send_good_q <= tx_send_good_d;
         tx_send_bad_q  <= tx_send_bad_d;
         busy_q         <= busy_d;
         pkt_done_q     <= pkt_done_d;
         hs_conflict_q  <= hs_conflict_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   assign tx_transmit  = tx_transmit_q;
   assign tx_send_good = tx_send_good_q;
   assign tx_send_bad  = tx_send_bad_q;
   assign busy         = busy_q;
   assign pkt_done     = pkt_done_q;
   assign hs_conflict  = hs_conflict_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// tb/tb_tx_scheduler.sv - scoreboard bench for tx_scheduler
module tb_tx_scheduler;

   localparam int CNT_W = 7;

   // Pulse event encoding: {tx_transmit, tx_send_good, tx_send_bad, pkt_done, hs_conflict}
   localparam logic [4:0] EV_TX   = 5'b10000;
   localparam logic [4:0] EV_GOOD = 5'b01000;
   localparam logic [4:0] EV_BAD  = 5'b00100;
   localparam logic [4:0] EV_DONE = 5'b00010;
   localparam logic [4:0] EV_CONF = 5'b00001;

   logic             clk = 1'b0;
   logic             n_rst = 1'b0;
   logic             ack_req = 1'b0;
   logic             nak_req = 1'b0;
   logic             data_req = 1'b0;
   logic             data_flush = 1'b0;
   logic [CNT_W-1:0] fifo_count = '0;
   logic             tx_busy = 1'b0;
   logic             clear_err = 1'b0;
   logic             tx_transmit, tx_send_good, tx_send_bad;
   logic             busy, pkt_done, hs_conflict, timeout_err;

   always #5 clk = ~clk;

   tx_scheduler #(
      .CNT_W         (CNT_W),
      .DATA_THRESH   (8),
      .GAP_CYCLES    (16),
      .START_TIMEOUT (8),
      .DONE_TIMEOUT  (4096),
      .STARVE_LIMIT  (4)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .ack_req      (ack_req),
      .nak_req      (nak_req),
      .data_req     (data_req),
      .data_flush   (data_flush),
      .fifo_count   (fifo_count),
      .tx_busy      (tx_busy),
      .clear_err    (clear_err),
      .tx_transmit  (tx_transmit),
      .tx_send_good (tx_send_good),
      .tx_send_bad  (tx_send_bad),
      .busy         (busy),
      .pkt_done     (pkt_done),
      .hs_conflict  (hs_conflict),
      .timeout_err  (timeout_err)
   );

   typedef struct {
      logic [4:0] ev;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   base = 0;
   bit   respond_en = 1'b1;
   int   busy_len = 18;

   logic [4:0] mon_ev;
   exp_t       mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every cycle with any pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      mon_ev = {tx_transmit, tx_send_good, tx_send_bad, pkt_done, hs_conflict};
      if (mon_ev != 5'b0) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pulse: got ev=%b at cycle %0d, required no pulse", mon_ev, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.ev !== mon_ev || mon_e.cyc != cyc) begin
               n_err++;
               $display("FAIL pulse: got ev=%b at cycle %0d, required ev=%b at cycle %0d",
                        mon_ev, cyc, mon_e.ev, mon_e.cyc);
            end
         end
      end
   end

   // Transmit unit model: tx_busy rises two cycles after a start pulse and stays high busy_len cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (respond_en && n_rst && (tx_transmit || tx_send_good || tx_send_bad)) begin
            @(posedge clk); #2;
            @(posedge clk); #2;
            tx_busy = 1'b1;
            repeat (busy_len) begin @(posedge clk); #2; end
            tx_busy = 1'b0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic goto_rel(input int rel);
      while (cyc < base + rel) step(1);
   endtask

   task automatic expect_ev(input logic [4:0] ev, input int rel);
      exp_t e;
      e.ev  = ev;
      e.cyc = base + rel;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic pulse(input logic a, input logic n, input logic d);
      ack_req  = a;
      nak_req  = n;
      data_req = d;
      step(1);
      ack_req  = 1'b0;
      nak_req  = 1'b0;
      data_req = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin step(1); n++; end
      chk("drain_missing", 8'(exp_q.size()), 8'd0);
      exp_q.delete();
      n = 0;
      while (busy !== 1'b0 && n < 100) begin step(1); n++; end
      chk("settle_idle", 8'(busy), 8'd0);
      step(2);
   endtask

   function automatic logic [7:0] all_outs();
      return {1'b0, tx_transmit, tx_send_good, tx_send_bad, busy, pkt_done, hs_conflict, timeout_err};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      // Reset values
      step(3);
      chk("reset_outs", all_outs(), 8'h00);
      n_rst = 1'b1;
      step(2);
      chk("post_reset_outs", all_outs(), 8'h00);

      // ACK: pulse at 1, done at 22, second ACK held through the gap to 39
      base = cyc;
      expect_ev(EV_GOOD, 1);
      expect_ev(EV_DONE, 22);
      expect_ev(EV_GOOD, 39);
      expect_ev(EV_DONE, 60);
      pulse(1'b1, 1'b0, 1'b0);
      goto_rel(2);
      chk("ack_busy", 8'(busy), 8'd1);
      goto_rel(5);
      pulse(1'b1, 1'b0, 1'b0);
      goto_rel(37);
      chk("gap_last_busy", 8'(busy), 8'd1);
      goto_rel(38);
      chk("gap_end_idle", 8'(busy), 8'd0);
      drain(200);

      // ACK+NAK together: one NAK with conflict, ACK dropped
      base = cyc;
      expect_ev(EV_BAD | EV_CONF, 1);
      expect_ev(EV_DONE, 22);
      pulse(1'b1, 1'b1, 1'b0);
      drain(200);
      step(40);

      // Data below threshold holds, launches when FIFO reaches 8
      base = cyc;
      fifo_count = 7'd5;
      pulse(1'b0, 1'b0, 1'b1);
      goto_rel(10);
      expect_ev(EV_TX, 11);
      expect_ev(EV_DONE, 32);
      fifo_count = 7'd8;
      drain(200);

      // Flush launches data at 7 bytes
      base = cyc;
      fifo_count = 7'd7;
      pulse(1'b0, 1'b0, 1'b1);
      goto_rel(5);
      expect_ev(EV_TX, 6);
      expect_ev(EV_DONE, 27);
      data_flush = 1'b1;
      step(1);
      data_flush = 1'b0;
      drain(200);

      // Starvation: 4 ACKs, then data, then the 5th ACK
      base = cyc;
      fifo_count = 7'd8;
      for (int k = 0; k < 4; k++) begin
         expect_ev(EV_GOOD, 1 + 38 * k);
         expect_ev(EV_DONE, 22 + 38 * k);
      end
      expect_ev(EV_TX, 153);
      expect_ev(EV_DONE, 174);
      expect_ev(EV_GOOD, 191);
      expect_ev(EV_DONE, 212);
      pulse(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         goto_rel(4 + 38 * k);
         pulse(1'b1, 1'b0, 1'b0);
      end
      drain(400);
      fifo_count = 7'd0;

      // Start timeout: tx_busy never rises after NAK
      respond_en = 1'b0;
      base = cyc;
      expect_ev(EV_BAD, 1);
      pulse(1'b0, 1'b1, 1'b0);
      goto_rel(8);
      chk("err_before_timeout", 8'(timeout_err), 8'd0);
      goto_rel(9);
      chk("err_at_timeout", 8'(timeout_err), 8'd1);
      goto_rel(24);
      chk("timeout_gap_busy", 8'(busy), 8'd1);
      goto_rel(25);
      chk("timeout_idle", 8'(busy), 8'd0);
      chk("err_sticky", 8'(timeout_err), 8'd1);
      goto_rel(26);
      clear_err = 1'b1;
      step(1);
      clear_err = 1'b0;
      chk("err_cleared", 8'(timeout_err), 8'd0);
      respond_en = 1'b1;
      drain(50);

      // Reset during WAIT_DONE with an ACK pending
      base = cyc;
      expect_ev(EV_GOOD, 1);
      pulse(1'b1, 1'b0, 1'b0);
      goto_rel(5);
      pulse(1'b1, 1'b0, 1'b0);
      goto_rel(10);
      chk("pre_reset_busy", 8'(busy), 8'd1);
      n_rst = 1'b0;
      #1;
      chk("async_reset_outs", all_outs(), 8'h00);
      step(2);
      n_rst = 1'b1;
      goto_rel(92);
      chk("no_pulse_after_reset", 8'(exp_q.size()), 8'd0);
      base = cyc;
      expect_ev(EV_GOOD, 1);
      expect_ev(EV_DONE, 22);
      pulse(1'b1, 1'b0, 1'b0);
      drain(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
